// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the write requesters, the shared FIFO write port
// and the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    // master drives requests and FIFO status; slave is the arbiter
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter granting one of NUM_REQ requesters the shared
// FIFO write port for up to BURST_MAX accepted beats per grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic              aclk,
    input  logic              areset,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_id_q;
    logic [CNT_W-1:0]       beat_cnt;
    logic [ID_W-1:0]        sel_idx;
    logic [ID_W-1:0]        cand;
    logic                   sel_found;
    logic                   holder_valid;
    logic                   accept;
    logic [ID_W-1:0]        next_ptr;
    logic [DATA_WIDTH-1:0]  slices [NUM_REQ];

    // Walk from the farthest candidate back to rr_ptr so the nearest valid one wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slices[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign holder_valid = bus.req_valid[grant_id_q];
    assign accept       = (state == GRANT) && holder_valid && !bus.fifo_full && !areset;
    assign next_ptr     = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_id_q] = 1'b1;
        end
    end

    assign bus.fifo_wr_en   = accept;
    assign bus.fifo_wr_data = slices[grant_id_q];
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = (state == GRANT) && !areset;

    // A full stall never ends a grant; only a completed burst or a drained requester does
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id_q <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id_q <= sel_idx;
                        beat_cnt   <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == CNT_W'(BURST_MAX - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!holder_valid && !bus.fifo_full) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
